// File: rtl/ccd_frame_sequencer.sv
// ccd_frame_sequencer: ICG/SH frame timing and per-pixel ADC strobes for a linear CCD.
// Define CCD_DUMMY_MASK_EN to strobe only the effective pixels 32..3679, re-indexed from 0.
module ccd_frame_sequencer #(
   parameter int PIXELS      = 3694,
   parameter int CLK_PER_PIX = 4,
   parameter int T_LEAD      = 10,
   parameter int T_TRAIL     = 1
) (
   input  logic        Master_clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] cfg_sh_width,
   input  logic [31:0] cfg_int_period,
   input  logic [15:0] cfg_frames,
   output logic        busy,
   output logic        CCD_ICG,
   output logic        CCD_SH,
   output logic        pix_valid,
   output logic [11:0] pix_index,
   output logic        frame_done,
   output logic        cfg_err
);
   localparam int PW = $clog2(CLK_PER_PIX + 1);
   localparam logic [PW-1:0] PPH_LAST = PW'(CLK_PER_PIX - 1);
   localparam logic [11:0] PIX_LAST = 12'(PIXELS - 1);
   localparam logic [31:0] LEAD = 32'(T_LEAD);
   localparam logic [31:0] EDGES = 32'(T_LEAD + T_TRAIL);
`ifdef CCD_DUMMY_MASK_EN
   localparam logic [11:0] EFF_FIRST = 12'd32;
   localparam logic [11:0] EFF_LAST = 12'd3679;
`endif

   typedef enum logic [1:0] {IDLE, ICG_PULSE, READOUT} state_t;

   state_t r_state, w_state_n;
   logic [31:0] r_cnt, w_cnt_n, r_ph, w_ph_n, r_ip, w_ip_n, w_ip_c;
   logic [15:0] r_sh_w, w_sh_n, w_sh_c, r_frames, w_frames_n, r_fcnt, w_fcnt_n;
   logic [PW-1:0] r_pph, w_pph_n;
   logic [11:0] r_pix, w_pix_n, w_idx_n, r_pix_index;
   logic r_stop_pend, r_busy, r_icg, r_sh, r_valid, r_frame_done, r_err;
   logic w_short, w_clamp, w_go, w_latch, w_last_icg, w_end_run;
   logic w_strobe_n, w_valid_n, w_sh_out_n, w_last_n, w_err_n;

   assign busy = r_busy;
   assign CCD_ICG = r_icg;
   assign CCD_SH = r_sh;
   assign pix_valid = r_valid;
   assign pix_index = r_pix_index;
   assign frame_done = r_frame_done;
   assign cfg_err = r_err;

   // r_ph is the distance from the most recent SH rise; it restarts at the ICG-phase rise and on each shutter period.
   always_comb begin
      w_sh_c = (cfg_sh_width == 16'd0) ? 16'd1 : cfg_sh_width;
      w_short = (cfg_int_period != 32'd0) && (cfg_int_period <= {16'd0, w_sh_c});
      w_clamp = (cfg_sh_width == 16'd0) || w_short;
      w_ip_c = w_short ? 32'd0 : cfg_int_period;
      w_go = (r_state == IDLE) && start && !stop;
      w_last_icg = (r_state == ICG_PULSE) && (r_cnt == EDGES + {16'd0, r_sh_w} - 32'd1);
      w_end_run = r_stop_pend || stop || (r_frames != 16'd0 && r_fcnt + 16'd1 == r_frames);
      w_latch = w_go || (r_frame_done && !w_end_run);
      w_state_n = w_go ? ICG_PULSE : w_last_icg ? READOUT : r_frame_done ? (w_end_run ? IDLE : ICG_PULSE) : r_state;
      w_cnt_n = (w_state_n == ICG_PULSE && r_state == ICG_PULSE) ? r_cnt + 32'd1 : 32'd0;
      w_sh_n = w_latch ? w_sh_c : r_sh_w;
      w_ip_n = w_latch ? w_ip_c : r_ip;
      w_frames_n = w_latch ? cfg_frames : r_frames;
      w_fcnt_n = w_go ? 16'd0 : (r_frame_done && !w_end_run) ? r_fcnt + 16'd1 : r_fcnt;
      w_err_n = w_go ? w_clamp : r_err | (w_latch & w_clamp);
      w_ph_n = (w_state_n != READOUT && w_cnt_n <= LEAD) ? 32'd0 : (r_ph + 32'd1 == r_ip) ? 32'd0 : r_ph + 32'd1;
      w_pph_n = (w_state_n == READOUT && r_state == READOUT && r_pph != PPH_LAST) ? r_pph + PW'(1) : '0;
      w_pix_n = (w_state_n != READOUT || r_state != READOUT) ? 12'd0 : (r_pph == PPH_LAST) ? r_pix + 12'd1 : r_pix;
      w_strobe_n = (w_state_n == READOUT) && (w_pph_n == PPH_LAST);
`ifdef CCD_DUMMY_MASK_EN
      w_valid_n = w_strobe_n && (w_pix_n >= EFF_FIRST) && (w_pix_n <= EFF_LAST);
      w_idx_n = w_pix_n - EFF_FIRST;
`else
      w_valid_n = w_strobe_n;
      w_idx_n = w_pix_n;
`endif
      w_sh_out_n = (w_state_n == ICG_PULSE && w_cnt_n >= LEAD && w_ph_n < {16'd0, w_sh_n}) ||
                   (w_state_n == READOUT && r_ip != 32'd0 && w_ph_n < {16'd0, r_sh_w});
      w_last_n = (w_state_n == READOUT) && (w_pix_n == PIX_LAST) && (w_pph_n == PPH_LAST);
   end

   always_ff @(posedge Master_clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt <= '0;
         r_ph <= '0;
         r_ip <= '0;
         r_sh_w <= '0;
         r_frames <= '0;
         r_fcnt <= '0;
         r_pph <= '0;
         r_pix <= '0;
         r_pix_index <= '0;
         r_stop_pend <= 1'b0;
         r_busy <= 1'b0;
         r_icg <= 1'b0;
         r_sh <= 1'b0;
         r_valid <= 1'b0;
         r_frame_done <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt <= w_cnt_n;
         r_ph <= w_ph_n;
         r_ip <= w_ip_n;
         r_sh_w <= w_sh_n;
         r_frames <= w_frames_n;
         r_fcnt <= w_fcnt_n;
         r_pph <= w_pph_n;
         r_pix <= w_pix_n;
         r_pix_index <= w_valid_n ? w_idx_n : r_pix_index;
         r_stop_pend <= (w_state_n == IDLE) ? 1'b0 : (r_stop_pend | stop);
         r_busy <= (w_state_n != IDLE);
         r_icg <= (w_state_n == ICG_PULSE);
         r_sh <= w_sh_out_n;
         r_valid <= w_valid_n;
         r_frame_done <= w_last_n;
         r_err <= w_err_n;
      end
   end
endmodule

// File: tb/tb_ccd_frame_sequencer.sv
// tb_ccd_frame_sequencer: frame-time model compared every cycle, plus literal timing checks.
module tb_ccd_frame_sequencer;
   localparam int R = 3694 * 4;
`ifdef CCD_DUMMY_MASK_EN
   localparam bit MASK = 1'b1;
`else
   localparam bit MASK = 1'b0;
`endif

   logic Master_clk, rst, start, stop;
   logic [15:0] cfg_sh_width, cfg_frames;
   logic [31:0] cfg_int_period;
   logic busy, CCD_ICG, CCD_SH, pix_valid, frame_done, cfg_err;
   logic [11:0] pix_index;

   int vectors = 0, miscompares = 0;

   ccd_frame_sequencer dut (
      .Master_clk(Master_clk), .rst(rst), .start(start), .stop(stop),
      .cfg_sh_width(cfg_sh_width), .cfg_int_period(cfg_int_period), .cfg_frames(cfg_frames),
      .busy(busy), .CCD_ICG(CCD_ICG), .CCD_SH(CCD_SH), .pix_valid(pix_valid),
      .pix_index(pix_index), .frame_done(frame_done), .cfg_err(cfg_err)
   );

   initial Master_clk = 1'b0;
   always #5 Master_clk = ~Master_clk;

   function automatic logic [17:0] outs();
      return {busy, CCD_ICG, CCD_SH, pix_valid, frame_done, cfg_err, pix_index};
   endfunction

   // Model: m_t is the cycle number inside the current frame; outputs follow from frame arithmetic.
   int m_busy = 0, m_t = 0, m_sh = 0, m_L = 0, m_fr = 0, m_fd = 0, m_pend = 0, m_err = 0, m_idx = 0;
   longint m_ip = 0;
   logic [17:0] e_vec = '0, a_vec;

   task automatic latch(input bit fresh);
      int s;
      bit cl;
      s = (cfg_sh_width == 16'd0) ? 1 : int'(cfg_sh_width);
      cl = (cfg_sh_width == 16'd0) || (cfg_int_period != 0 && longint'(cfg_int_period) < s + 1);
      m_sh = s;
      m_ip = (cfg_int_period != 0 && longint'(cfg_int_period) < s + 1) ? 0 : longint'(cfg_int_period);
      m_L = 10 + s + 1;
      m_fr = int'(cfg_frames);
      m_err = fresh ? int'(cl) : (m_err | int'(cl));
   endtask

   always @(posedge Master_clk) begin
      int r, raw;
      bit e_icg, e_sh, e_val, e_done;
      if (!rst) begin
         m_busy = 0; m_t = 0; m_err = 0; m_idx = 0; m_pend = 0;
      end else if (m_busy == 0) begin
         if (start && !stop) begin latch(1'b1); m_fd = 0; m_pend = 0; m_busy = 1; m_t = 0; end
      end else begin
         if (stop) m_pend = 1;
         if (m_t == m_L + R - 1) begin
            m_fd++;
            if (m_pend != 0 || (m_fr != 0 && m_fd == m_fr)) begin m_busy = 0; m_pend = 0; end
            else begin latch(1'b0); m_t = 0; end
         end else m_t++;
      end
      r = m_t - m_L;
      raw = r / 4;
      e_icg = (m_busy != 0) && m_t < m_L;
      e_sh = (m_busy != 0) && ((m_t >= 10 && m_t < 10 + m_sh) ||
             (m_ip != 0 && m_t >= m_L && (m_t - 10) >= m_ip && ((m_t - 10) % m_ip) < m_sh));
      e_val = (m_busy != 0) && m_t >= m_L && (r % 4) == 3 && (!MASK || (raw >= 32 && raw <= 3679));
      if (e_val) m_idx = MASK ? raw - 32 : raw;
      e_done = (m_busy != 0) && m_t == m_L + R - 1;
      e_vec = {m_busy != 0, e_icg, e_sh, e_val, e_done, m_err != 0, 12'(m_idx)};
   end

   always @(negedge Master_clk) begin
      a_vec = outs();
      vectors++;
      if (a_vec !== (rst ? e_vec : 18'd0)) begin
         miscompares++;
         $display("FAIL cycle t=%0t dut=%h model=%h", $time, a_vec, rst ? e_vec : 18'd0);
      end
   end

   // Frame monitor: cyc 0 is the first cycle after start is accepted.
   bit meas = 0, p_sh = 0;
   int cyc, icg_run, sh_run, strobes, first_strobe, first_idx, last_idx, last_strobe, bad_gap, busy_cnt;
   int icg_lens[$], sh_rises[$], sh_lens[$], done_at[$];

   always @(posedge Master_clk) begin
      #1;
      if (meas) begin
         if (CCD_ICG) icg_run++; else if (icg_run > 0) begin icg_lens.push_back(icg_run); icg_run = 0; end
         if (CCD_SH && !p_sh) sh_rises.push_back(cyc);
         if (CCD_SH) sh_run++; else if (sh_run > 0) begin sh_lens.push_back(sh_run); sh_run = 0; end
         p_sh = CCD_SH;
         if (pix_valid) begin
            if (strobes == 0) begin first_strobe = cyc; first_idx = int'(pix_index); end
            else if (cyc - last_strobe != 4) bad_gap++;
            last_strobe = cyc; last_idx = int'(pix_index); strobes++;
         end
         if (frame_done) done_at.push_back(cyc);
         if (busy) busy_cnt++;
         cyc++;
      end
   end

   task automatic check(input string name, input longint act, input longint exp_v);
      vectors++;
      if (act != exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   task automatic go(input logic [15:0] sh, input logic [31:0] ip, input logic [15:0] fr);
      @(negedge Master_clk);
      cfg_sh_width = sh; cfg_int_period = ip; cfg_frames = fr; start = 1'b1;
      icg_lens.delete(); sh_rises.delete(); sh_lens.delete(); done_at.delete();
      cyc = 0; icg_run = 0; sh_run = 0; p_sh = 0; strobes = 0; bad_gap = 0; busy_cnt = 0;
      first_strobe = -1; first_idx = -1; last_idx = -1; last_strobe = 0;
      meas = 1'b1;
      @(negedge Master_clk);
      start = 1'b0;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge Master_clk);
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (busy && n < bound) begin @(negedge Master_clk); n++; end
      if (busy) begin
         vectors++; miscompares++;
         $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", bound);
      end
      @(negedge Master_clk);
      meas = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      cfg_sh_width = '0; cfg_int_period = '0; cfg_frames = '0;
      #1 rst = 1'b0;
      repeat (3) @(negedge Master_clk);
      check("reset_outputs", outs(), 0);
      rst = 1'b1;
      // reset in the middle of readout
      go(16'd20, 32'd0, 16'd1);
      n = 0;
      while (pix_index != 12'd1200 && n < 20000) begin @(negedge Master_clk); n++; end
      check("reach_index_1200", pix_index, 1200);
      #2 rst = 1'b0;
      #1 check("async_reset_outputs", outs(), 0);
      meas = 1'b0;
      repeat (3) @(negedge Master_clk);
      rst = 1'b1;
      // single frame, also the clean frame after reset
      go(16'd20, 32'd0, 16'd1);
      wait_idle(20000);
      check("single_icg_frames", icg_lens.size(), 1);
      check("single_icg_len", icg_lens[0], 31);
      check("single_sh_rise", sh_rises[0], 10);
      check("single_sh_len", sh_lens[0], 20);
      check("single_strobes", strobes, MASK ? 3648 : 3694);
      check("single_first_strobe", first_strobe, MASK ? 162 : 34);
      check("single_first_idx", first_idx, 0);
      check("single_last_idx", last_idx, MASK ? 3647 : 3693);
      check("single_strobe_gaps", bad_gap, 0);
      check("single_done_at", done_at[0], 14806);
      check("single_busy_cycles", busy_cnt, 14807);
      check("single_cfg_err", cfg_err, 0);
      // electronic shutter
      go(16'd8, 32'd1000, 16'd1);
      wait_idle(20000);
      check("shut_rises", sh_rises.size(), 15);
      check("shut_rise0", sh_rises[0], 10);
      check("shut_rise1", sh_rises[1], 1010);
      check("shut_rise14", sh_rises[14], 14010);
      n = 0;
      foreach (sh_lens[i]) if (sh_lens[i] != 8) n++;
      check("shut_widths_not_8", n, 0);
      check("shut_done_at", done_at[0], 14794);
      // clamps
      go(16'd0, 32'd1, 16'd1);
      wait_idle(20000);
      check("clamp_cfg_err", cfg_err, 1);
      check("clamp_sh_pulses", sh_lens.size(), 1);
      check("clamp_sh_len", sh_lens[0], 1);
      check("clamp_icg_len", icg_lens[0], 12);
      check("clamp_busy_cycles", busy_cnt, 14788);
      check("clamp_done_at", done_at[0], 14787);
      // start and stop together: stop wins, cfg_err not cleared
      @(negedge Master_clk);
      cfg_sh_width = 16'd20; cfg_int_period = 32'd0; start = 1'b1; stop = 1'b1;
      @(negedge Master_clk);
      start = 1'b0; stop = 1'b0;
      @(negedge Master_clk);
      check("start_stop_busy", busy, 0);
      check("start_stop_err_kept", cfg_err, 1);
      // continuous with mid-frame config change, ignored start, then stop
      go(16'd20, 32'd0, 16'd0);
      check("cont_err_cleared", cfg_err, 0);
      wait_cyc(3000);
      start = 1'b1;
      @(negedge Master_clk);
      start = 1'b0;
      wait_cyc(5000);
      cfg_sh_width = 16'd40;
      wait_cyc(20000);
      stop = 1'b1;
      @(negedge Master_clk);
      stop = 1'b0;
      wait_idle(40000);
      check("cont_frames", icg_lens.size(), 2);
      check("cont_icg0", icg_lens[0], 31);
      check("cont_icg1", icg_lens[1], 51);
      check("cont_sh0", sh_lens[0], 20);
      check("cont_sh1", sh_lens[1], 40);
      check("cont_done0", done_at[0], 14806);
      check("cont_done1", done_at[1], 29633);
      check("cont_busy_cycles", busy_cnt, 29634);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
